idu_pipe: RTL and testbench
===========================

# idu_pipe

Pipelined, parametrised RV32I/RV32E decode stage placed between the ifu and the execute unit. It accepts one instruction per cycle over a valid/ready handshake and decodes the full RV32I base set into a registered instruction bundle. A per-register scoreboard stalls issue on RAW and WAW hazards. It supports flush from branch redirect, and an EBREAK halt state machine replaces the old DPI ebreak call.

## Interface
- ADDR_WIDTH, 32, PC width
- DATA_WIDTH, 32, immediate width; immediates sign-extend to it
- REG_ADDR_WIDTH, 5, register index width; 4 gives RV32E
- CNT_WIDTH, 16, stall counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid_i  in  1  ifu has an instruction
- in_ready_o  out  1  decode accepts this cycle
- instr_i  in  32  instruction word
- pc_i  in  ADDR_WIDTH  instruction PC
- flush_i  in  1  redirect: discard the held bundle
- wb_en_i  in  1  writeback retires a register
- wb_rd_i  in  REG_ADDR_WIDTH  retired register index
- out_valid_o  out  1  bundle valid
- out_ready_i  in  1  exu takes the bundle
- out_pc_o  out  ADDR_WIDTH  PC of the held bundle
- out_rs1_o, out_rs2_o, out_rd_o  out  REG_ADDR_WIDTH each  register indices
- out_imm_o  out  DATA_WIDTH  immediate
- out_itype_o  out  4  0 INVLD, 1 R, 2 I_COMPU, 3 I_SHIFT, 4 LOAD, 5 STORE, 6 BRANCH, 7 JAL, 8 JALR, 9 LUI, 10 AUIPC, 11 ECALL, 12 EBREAK
- out_aluop_o  out  4  ALU operation
- out_use_rs1_o, out_use_rs2_o, out_use_imm_o, out_use_pc_o, out_use_rd_o, out_invld_o  out  1 each  operand and validity flags
- halt_o  out  1  core halted on EBREAK
- stall_cnt_o  out  CNT_WIDTH  saturating stall-cycle count

## Operation
- **Decode legality.** Decode uses the standard RV32I opcodes. An instruction is legal only under these rules:
  - R: func7 is 0, or func7 is 0x20 with func3 of 0 or 5.
  - I_COMPU: func3 is not 1 or 5.
  - I_SHIFT: func3 1 with func7 0, or func3 5 with func7 0 or 0x20.
  - LOAD: func3 in {0,1,2,4,5}.
  - STORE: func3 in {0,1,2}.
  - BRANCH: func3 is not 2 or 3.
  - JALR: func3 0.
  - ECALL/EBREAK: exact encodings 0x00000073 and 0x00100073.
  - Any used register field that does not fit in REG_ADDR_WIDTH makes the instruction illegal.
  - Anything else is INVLD.
- **Immediate formats.** I-format for I_COMPU, LOAD and JALR. Shamt is zero-extended instr[24:20]. S, B, U and J formats follow the ISA. All other types give 0.
- **aluop.**
  - R and I_SHIFT: {instr[30], func3}.
  - I_COMPU and BRANCH: {0, func3}.
  - All other types: 0 (add).
- **Use flags {rs1, rs2, imm, pc, rd}.**
  - R: 11001
  - I_COMPU, I_SHIFT, LOAD: 10101
  - STORE: 11100
  - BRANCH: 11110
  - JAL: 00111
  - JALR: 10111
  - LUI: 00101
  - AUIPC: 00111
  - ECALL, EBREAK, INVLD: 00000
  - use_rd is forced to 0 when rd = 0.
- **Scoreboard.**
  - One pending bit per register; x0 is never pending.
  - Hazard = (use_rs1 & pend[rs1]) | (use_rs2 & pend[rs2]) | (use_rd & pend[rd]).
  - Hazard is computed from instr_i and the registered bits only; there is no writeback bypass.
  - An accepted instruction with use_rd sets pend[rd].
  - wb_en_i clears pend[wb_rd_i].
  - If a set and a clear hit the same index in one cycle, the set wins.
- **Acceptance.** in_ready_o = (state == RUN) & ~flush_i & ~hazard & (~valid_q | out_ready_i).
- **Output validity.** out_valid_o = valid_q & ~flush_i.
- **Flush.**
  - Clears valid_q.
  - Clears pend[rd] of the held bundle if it had use_rd.
  - Blocks acceptance that cycle.
  - An exu handshake coinciding with flush_i does not count as taken.
- **Halt FSM.**
  - RUN: accepting EBREAK moves to HPEND.
  - HPEND: an output handshake of the EBREAK moves to HALT; flush_i returns to RUN.
  - HALT: halt_o = 1. Only rst exits.
- **Stall counter.** stall_cnt_o increments when in_valid_i & ~in_ready_o & state == RUN, and saturates at all-ones.

## Timing
- Decode latency is 1 cycle, from input handshake to out_valid_o.
- Throughput is 1 per cycle: a new bundle loads in the same cycle the held one is taken.
- Output fields are registered and stable while out_valid_o & ~out_ready_i.
- in_ready_o depends combinationally on instr_i, flush_i and out_ready_i.
- Reset values:
  - valid_q = 0, all pending bits = 0, state = RUN, stall counter = 0, halt_o = 0.
  - All bundle fields are 0, out_itype_o = INVLD.
- Reset mid-operation discards the held bundle and all scoreboard state immediately (asynchronous).

## Test plan
- **Back-to-back issue.** addi x1,x0,5 then addi x2,x0,7 with out_ready_i = 1.
  - Both issue on consecutive cycles.
  - imm = 5, then 7; aluop = 0.
  - pend[1] and pend[2] are set.
- **RAW stall.** addi x1,x0,1 then add x3,x1,x1, with no writeback.
  - in_ready_o stays 0 and stall_cnt_o increments each cycle.
  - Assert wb_en_i with wb_rd_i = 1: the add is accepted the following cycle.
- **Flush.** Flush while lw x5,8(x2) is held.
  - out_valid_o drops in the same cycle and pend[5] is cleared.
  - Next, sw x5,0(x2) is accepted, decoding to itype = 5, imm = 0, use_rd = 0.
- **Immediate decode.** beq x1,x2,-4 decodes to itype = 6, imm = 0xFFFFFFFC, aluop = 0, use_pc = 1. JAL with offset 0x800 decodes to imm = 0x00000800.
- **EBREAK halt.**
  - EBREAK accepted: state goes to HPEND and in_ready_o = 0.
  - After the output handshake: halt_o = 1.
  - Assert rst: halt_o returns to 0.
- **RV32E.** With REG_ADDR_WIDTH = 4, add x17,x1,x2 gives out_invld_o = 1 and sets no pending bit. funct7 = 0x01 on opcode 0x33 also gives INVLD.

Source files
------------

// File: rtl/idu_pipe.sv
// RV32I/RV32E decode stage: valid/ready in, registered instruction bundle out,
// per-register scoreboard for RAW/WAW stalls, flush on redirect and EBREAK halt FSM.
module idu_pipe #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               instr_i,
  input  logic [ADDR_WIDTH-1:0]     pc_i,
  input  logic                      flush_i,
  input  logic                      wb_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ADDR_WIDTH-1:0]     out_pc_o,
  output logic [REG_ADDR_WIDTH-1:0] out_rs1_o,
  output logic [REG_ADDR_WIDTH-1:0] out_rs2_o,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_o,
  output logic [DATA_WIDTH-1:0]     out_imm_o,
  output logic [3:0]                out_itype_o,
  output logic [3:0]                out_aluop_o,
  output logic                      out_use_rs1_o,
  output logic                      out_use_rs2_o,
  output logic                      out_use_imm_o,
  output logic                      out_use_pc_o,
  output logic                      out_use_rd_o,
  output logic                      out_invld_o,
  output logic                      halt_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

  localparam int NREG = 1 << REG_ADDR_WIDTH;

  typedef enum logic [3:0] {
    IT_INVLD   = 4'd0,
    IT_R       = 4'd1,
    IT_I_COMPU = 4'd2,
    IT_I_SHIFT = 4'd3,
    IT_LOAD    = 4'd4,
    IT_STORE   = 4'd5,
    IT_BRANCH  = 4'd6,
    IT_JAL     = 4'd7,
    IT_JALR    = 4'd8,
    IT_LUI     = 4'd9,
    IT_AUIPC   = 4'd10,
    IT_ECALL   = 4'd11,
    IT_EBREAK  = 4'd12
  } itype_e;

  typedef enum logic [1:0] {ST_RUN, ST_HPEND, ST_HALT} state_e;

  // Operand-use flags ordered {rs1, rs2, imm, pc, rd}.
  function automatic logic [4:0] use_of(input itype_e t);
    case (t)
      IT_R:                            return 5'b11001;
      IT_I_COMPU, IT_I_SHIFT, IT_LOAD: return 5'b10101;
      IT_STORE:                        return 5'b11100;
      IT_BRANCH:                       return 5'b11110;
      IT_JAL:                          return 5'b00111;
      IT_JALR:                         return 5'b10111;
      IT_LUI:                          return 5'b00101;
      IT_AUIPC:                        return 5'b00111;
      default:                         return 5'b00000;
    endcase
  endfunction

  function automatic logic reg_fits(input logic [4:0] f);
    return (f >> REG_ADDR_WIDTH) == 5'd0;
  endfunction

  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic [4:0] rs1_f, rs2_f, rd_f;

  assign opcode = instr_i[6:0];
  assign rd_f   = instr_i[11:7];
  assign func3  = instr_i[14:12];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];
  assign func7  = instr_i[31:25];

  logic [REG_ADDR_WIDTH-1:0] rs1_idx, rs2_idx, rd_idx;
  assign rs1_idx = rs1_f[REG_ADDR_WIDTH-1:0];
  assign rs2_idx = rs2_f[REG_ADDR_WIDTH-1:0];
  assign rd_idx  = rd_f[REG_ADDR_WIDTH-1:0];

  itype_e          cand, d_itype;
  logic [4:0]      cand_use, d_use;
  logic            regs_ok;
  logic [31:0]     imm32;
  logic [3:0]      d_aluop;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    cand = IT_INVLD;
    case (opcode)
      7'h33: if (func7 == 7'h00 || (func7 == 7'h20 && (func3 == 3'd0 || func3 == 3'd5)))
               cand = IT_R;
      7'h13: begin
        if (func3 == 3'd1) begin
          if (func7 == 7'h00) cand = IT_I_SHIFT;
        end else if (func3 == 3'd5) begin
          if (func7 == 7'h00 || func7 == 7'h20) cand = IT_I_SHIFT;
        end else begin
          cand = IT_I_COMPU;
        end
      end
      7'h03: if (func3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) cand = IT_LOAD;
      7'h23: if (func3 inside {3'd0, 3'd1, 3'd2}) cand = IT_STORE;
      7'h63: if (!(func3 inside {3'd2, 3'd3})) cand = IT_BRANCH;
      7'h6f: cand = IT_JAL;
      7'h67: if (func3 == 3'd0) cand = IT_JALR;
      7'h37: cand = IT_LUI;
      7'h17: cand = IT_AUIPC;
      7'h73: begin
        if (instr_i == 32'h0000_0073)      cand = IT_ECALL;
        else if (instr_i == 32'h0010_0073) cand = IT_EBREAK;
      end
      default: ;
    endcase
  end

  // A register field that does not fit the register file (RV32E) makes the encoding illegal.
  assign cand_use = use_of(cand);
  assign regs_ok  = (~cand_use[4] | reg_fits(rs1_f)) &
                    (~cand_use[3] | reg_fits(rs2_f)) &
                    (~cand_use[0] | reg_fits(rd_f));
  assign d_itype  = regs_ok ? cand : IT_INVLD;

  always_comb begin
    d_use    = use_of(d_itype);
    d_use[0] = d_use[0] & (rd_f != 5'd0);
  end

  always_comb begin
    imm32 = 32'd0;
    case (d_itype)
      IT_I_COMPU, IT_LOAD, IT_JALR: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IT_I_SHIFT: imm32 = {27'd0, instr_i[24:20]};
      IT_STORE:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IT_BRANCH:  imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
      IT_LUI, IT_AUIPC: imm32 = {instr_i[31:12], 12'd0};
      IT_JAL:     imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
      default:    imm32 = 32'd0;
    endcase
  end

  always_comb begin
    d_aluop = 4'd0;
    case (d_itype)
      IT_R, IT_I_SHIFT:      d_aluop = {instr_i[30], func3};
      IT_I_COMPU, IT_BRANCH: d_aluop = {1'b0, func3};
      default:               d_aluop = 4'd0;
    endcase
  end

  state_e          state_q;
  logic            valid_q;
  logic [NREG-1:0] pend_q, pend_d;
  logic            hazard, accept, take;

  assign hazard = (d_use[4] & pend_q[rs1_idx]) |
                  (d_use[3] & pend_q[rs2_idx]) |
                  (d_use[0] & pend_q[rd_idx]);

  assign in_ready_o  = (state_q == ST_RUN) & ~flush_i & ~hazard & (~valid_q | out_ready_i);
  assign out_valid_o = valid_q & ~flush_i;
  assign accept      = in_valid_i & in_ready_o;
  assign take        = valid_q & out_ready_i & ~flush_i;

  // Clears are applied first so a same-cycle set of the same register wins.
  always_comb begin
    pend_d = pend_q;
    if (wb_en_i) pend_d[wb_rd_i] = 1'b0;
    if (flush_i && valid_q && out_use_rd_o) pend_d[out_rd_o] = 1'b0;
    if (accept && d_use[0]) pend_d[rd_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Register indices are passed through raw; the use flags say which ones matter.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the pending bits are plain flops and are reset, so no stale hazard survives reset.
      valid_q       <= 1'b0;
      pend_q        <= '0;
      out_pc_o      <= '0;
      out_rs1_o     <= '0;
      out_rs2_o     <= '0;
      out_rd_o      <= '0;
      out_imm_o     <= '0;
      out_itype_o   <= IT_INVLD;
      out_aluop_o   <= '0;
      out_use_rs1_o <= 1'b0;
      out_use_rs2_o <= 1'b0;
      out_use_imm_o <= 1'b0;
      out_use_pc_o  <= 1'b0;
      out_use_rd_o  <= 1'b0;
      out_invld_o   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (flush_i)     valid_q <= 1'b0;
      else if (accept) valid_q <= 1'b1;
      else if (take)   valid_q <= 1'b0;
      if (accept) begin
        out_pc_o      <= pc_i;
        out_rs1_o     <= rs1_idx;
        out_rs2_o     <= rs2_idx;
        out_rd_o      <= rd_idx;
        out_imm_o     <= DATA_WIDTH'($signed(imm32));
        out_itype_o   <= d_itype;
        out_aluop_o   <= d_aluop;
        out_use_rs1_o <= d_use[4];
        out_use_rs2_o <= d_use[3];
        out_use_imm_o <= d_use[2];
        out_use_pc_o  <= d_use[1];
        out_use_rd_o  <= d_use[0];
        out_invld_o   <= (d_itype == IT_INVLD);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      halt_o      <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      case (state_q)
        ST_RUN:   if (accept && d_itype == IT_EBREAK) state_q <= ST_HPEND;
        ST_HPEND: begin
          if (flush_i) begin
            state_q <= ST_RUN;
          end else if (take) begin
            state_q <= ST_HALT;
            halt_o  <= 1'b1;
          end
        end
        default: ;
      endcase
      if (in_valid_i && !in_ready_o && state_q == ST_RUN && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: directed instruction vectors, expected bundles queued at issue
// and compared by an independent monitor on each output handshake.
module tb_idu_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  itype, aluop;
    logic [5:0]  flags;  // {use_rs1, use_rs2, use_imm, use_pc, use_rd, invld}
  } bundle_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0, rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready, halt;
  logic [31:0] instr, pc, out_pc, out_imm;
  logic [4:0]  wb_rd, out_rs1, out_rs2, out_rd;
  logic [3:0]  out_itype, out_aluop;
  logic        u_rs1, u_rs2, u_imm, u_pc, u_rd, invld;
  logic [15:0] stall_cnt;

  idu_pipe dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .wb_en_i(wb_en), .wb_rd_i(wb_rd),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
    .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_o(out_rd), .out_imm_o(out_imm),
    .out_itype_o(out_itype), .out_aluop_o(out_aluop), .out_use_rs1_o(u_rs1),
    .out_use_rs2_o(u_rs2), .out_use_imm_o(u_imm), .out_use_pc_o(u_pc),
    .out_use_rd_o(u_rd), .out_invld_o(invld), .halt_o(halt), .stall_cnt_o(stall_cnt)
  );

  // RV32E instance, driven separately.
  logic        e_in_valid, e_in_ready, e_out_valid, e_halt;
  logic [31:0] e_instr, e_out_pc, e_out_imm;
  logic [3:0]  e_out_rs1, e_out_rs2, e_out_rd, e_out_itype, e_out_aluop;
  logic        e_u_rs1, e_u_rs2, e_u_imm, e_u_pc, e_u_rd, e_invld;
  logic [15:0] e_stall_cnt;

  idu_pipe #(.REG_ADDR_WIDTH(4)) dut_e (
    .clk(clk), .rst(rst), .in_valid_i(e_in_valid), .in_ready_o(e_in_ready),
    .instr_i(e_instr), .pc_i(32'h200), .flush_i(1'b0), .wb_en_i(1'b0), .wb_rd_i(4'd0),
    .out_valid_o(e_out_valid), .out_ready_i(1'b1), .out_pc_o(e_out_pc),
    .out_rs1_o(e_out_rs1), .out_rs2_o(e_out_rs2), .out_rd_o(e_out_rd), .out_imm_o(e_out_imm),
    .out_itype_o(e_out_itype), .out_aluop_o(e_out_aluop), .out_use_rs1_o(e_u_rs1),
    .out_use_rs2_o(e_u_rs2), .out_use_imm_o(e_u_imm), .out_use_pc_o(e_u_pc),
    .out_use_rd_o(e_u_rd), .out_invld_o(e_invld), .halt_o(e_halt), .stall_cnt_o(e_stall_cnt)
  );

  int n_tests = 0, n_fail = 0, n_seen = 0;
  bundle_t exp_q[$];
  bundle_t mon_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end
  endtask

  function automatic bundle_t mk(input logic [31:0] p, input logic [4:0] r1, r2, rd,
                                 input logic [31:0] im, input logic [3:0] it, op,
                                 input logic [5:0] fl);
    bundle_t b;
    b.pc = p; b.rs1 = r1; b.rs2 = r2; b.rd = rd; b.imm = im;
    b.itype = it; b.aluop = op; b.flags = fl;
    return b;
  endfunction

  // Monitor: every output handshake pops the oldest expected bundle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_bundle: got pc 0x%0h, required no bundle", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("pc[%0d]", n_seen), out_pc, mon_e.pc);
        check($sformatf("rs1[%0d]", n_seen), out_rs1, mon_e.rs1);
        check($sformatf("rs2[%0d]", n_seen), out_rs2, mon_e.rs2);
        check($sformatf("rd[%0d]", n_seen), out_rd, mon_e.rd);
        check($sformatf("imm[%0d]", n_seen), out_imm, mon_e.imm);
        check($sformatf("itype[%0d]", n_seen), out_itype, mon_e.itype);
        check($sformatf("aluop[%0d]", n_seen), out_aluop, mon_e.aluop);
        check($sformatf("flags[%0d]", n_seen), {u_rs1, u_rs2, u_imm, u_pc, u_rd, invld},
              mon_e.flags);
      end
      n_seen++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one instruction until accepted; returns the number of stalled cycles.
  task automatic issue(input logic [31:0] i, input logic [31:0] p, input bundle_t e,
                       output int waits);
    in_valid = 1'b1; instr = i; pc = p; waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin exp_q.push_back(e); break; end
      waits++;
      if (waits >= 20) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: got no acceptance of 0x%0h in %0d cycles, required acceptance",
                 i, waits);
        break;
      end
    end
    tick();
    in_valid = 1'b0; instr = NOP;
  endtask

  task automatic probe_ready(input string name, input logic [31:0] i, input logic want);
    instr = i;
    @(negedge clk);
    check(name, in_ready, want);
    tick();
  endtask

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; instr = NOP; pc = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; out_ready = 1'b1;
    e_in_valid = 1'b0; e_instr = NOP;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_stall_cnt", stall_cnt, 16'd0);
    check("rst_itype", out_itype, 4'd0);
    check("rst_imm", out_imm, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    rst = 1'b0;
    tick();

    // Back-to-back issue.
    issue(32'h0050_0093, 32'h100, mk(32'h100, 5'd0, 5'd5, 5'd1, 32'd5, 4'd2, 4'd0, 6'b101010), w);
    issue(32'h0070_0113, 32'h104, mk(32'h104, 5'd0, 5'd7, 5'd2, 32'd7, 4'd2, 4'd0, 6'b101010), w);
    check("b2b_waits", w, 0);
    probe_ready("pend1_set", 32'h0000_8213, 1'b0);
    probe_ready("pend2_set", 32'h0001_0213, 1'b0);
    probe_ready("pend3_clear", 32'h0001_8213, 1'b1);
    wb_en = 1'b1; wb_rd = 5'd1; tick();
    wb_rd = 5'd2; tick();
    wb_en = 1'b0;

    // RAW stall on x1, released by writeback.
    issue(32'h0010_0093, 32'h108, mk(32'h108, 5'd0, 5'd1, 5'd1, 32'd1, 4'd2, 4'd0, 6'b101010), w);
    in_valid = 1'b1; instr = 32'h0010_81b3; pc = 32'h10c;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("raw_ready_%0d", k), in_ready, 1'b0);
      check($sformatf("raw_stall_%0d", k), stall_cnt, 16'(k));
      tick();
    end
    wb_en = 1'b1; wb_rd = 5'd1;
    @(negedge clk);
    check("raw_no_bypass", in_ready, 1'b0);
    tick();
    wb_en = 1'b0;
    @(negedge clk);
    check("raw_released", in_ready, 1'b1);
    check("raw_stall_total", stall_cnt, 16'd4);
    if (in_ready) exp_q.push_back(mk(32'h10c, 5'd1, 5'd1, 5'd3, 32'd0, 4'd1, 4'd0, 6'b110010));
    tick();
    in_valid = 1'b0; instr = NOP;
    tick();

    // Flush of a held load.
    out_ready = 1'b0;
    issue(32'h0081_2283, 32'h110, mk(32'h110, 5'd2, 5'd8, 5'd5, 32'd8, 4'd4, 4'd0, 6'b101010), w);
    @(negedge clk);
    check("lw_held", out_valid, 1'b1);
    tick();
    flush = 1'b1;
    #1;
    check("flush_drops_valid", out_valid, 1'b0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    tick();
    flush = 1'b0; out_ready = 1'b1;
    instr = 32'h0002_8313;
    @(negedge clk);
    check("flush_valid_cleared", out_valid, 1'b0);
    check("flush_pend5_cleared", in_ready, 1'b1);
    tick();
    issue(32'h0051_2023, 32'h114, mk(32'h114, 5'd2, 5'd5, 5'd0, 32'd0, 4'd5, 4'd0, 6'b111000), w);

    // Immediate formats and misc decode.
    issue(32'hfe20_8ee3, 32'h118,
          mk(32'h118, 5'd1, 5'd2, 5'd29, 32'hffff_fffc, 4'd6, 4'd0, 6'b111100), w);
    issue(32'h0010_00ef, 32'h11c, mk(32'h11c, 5'd0, 5'd1, 5'd1, 32'h800, 4'd7, 4'd0, 6'b001110), w);
    issue(32'h4094_03b3, 32'h120, mk(32'h120, 5'd8, 5'd9, 5'd7, 32'd0, 4'd1, 4'd8, 6'b110010), w);
    issue(32'h4035_d513, 32'h124, mk(32'h124, 5'd11, 5'd3, 5'd10, 32'd3, 4'd3, 4'd13, 6'b101010), w);
    issue(32'h4000_1013, 32'h128, mk(32'h128, 5'd0, 5'd0, 5'd0, 32'd0, 4'd0, 4'd0, 6'b000001), w);
    issue(32'h1234_5637, 32'h12c,
          mk(32'h12c, 5'd8, 5'd3, 5'd12, 32'h1234_5000, 4'd9, 4'd0, 6'b001010), w);
    tick();

    // EBREAK halt.
    out_ready = 1'b0;
    issue(32'h0010_0073, 32'h134, mk(32'h134, 5'd0, 5'd1, 5'd0, 32'd0, 4'd12, 4'd0, 6'b000000), w);
    @(negedge clk);
    check("hpend_not_ready", in_ready, 1'b0);
    check("hpend_not_halted", halt, 1'b0);
    check("hpend_valid", out_valid, 1'b1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("halt_before_take", halt, 1'b0);
    tick();
    @(negedge clk);
    check("halted", halt, 1'b1);
    check("halt_not_ready", in_ready, 1'b0);
    check("halt_stall_cnt", stall_cnt, 16'd4);
    #2 rst = 1'b1;
    #1;
    check("rst_clears_halt", halt, 1'b0);
    check("rst_clears_stall", stall_cnt, 16'd0);
    check("rst_clears_valid", out_valid, 1'b0);
    #3 rst = 1'b0;
    tick();
    probe_ready("rst_clears_pend3", 32'h0001_8213, 1'b1);

    // RV32E: x16..x31 are illegal, funct7 0x01 is illegal.
    e_in_valid = 1'b1; e_instr = 32'h0020_88b3;
    @(negedge clk);
    check("e_x17_accept", e_in_ready, 1'b1);
    tick();
    e_instr = 32'h0000_8213;
    @(negedge clk);
    check("e_x17_invld", e_invld, 1'b1);
    check("e_x17_itype", e_out_itype, 4'd0);
    check("e_x17_no_pend", e_in_ready, 1'b1);
    tick();
    e_instr = 32'h0220_81b3;
    tick();
    e_instr = 32'h0020_81b3;
    @(negedge clk);
    check("e_f7_invld", e_invld, 1'b1);
    check("e_f7_itype", e_out_itype, 4'd0);
    tick();
    e_in_valid = 1'b0; e_instr = 32'h0001_8213;
    @(negedge clk);
    check("e_add_itype", e_out_itype, 4'd1);
    check("e_add_pend3", e_in_ready, 1'b0);
    tick();

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
